// File: rtl/uart_frame_rx_pkg.sv
// Shared types and helpers for the UART frame receiver and the planned TX framer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } frame_state_e;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

  // Running frame checksum: XOR of LEN and every payload byte.
  function automatic logic [7:0] frame_chk(input logic [7:0] acc, input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction

endpackage

// File: rtl/uart_frame_rx_frame_buf.sv
// Payload store: DEPTH x 8 register array, one synchronous write port, combinational read.
module frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [DEPTH-1:0][7:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0] entry_q;

      always_ff @(posedge clk) begin
        if (we_i && (waddr_i == AW'(gi))) begin
          entry_q <= wdata_i;
        end
      end

      // Out-of-range read addresses select no entry and read back zero.
      assign sel_data[gi] = (raddr_i == AW'(gi)) ? entry_q : 8'h00;
    end
  endgenerate

  always_comb begin
    rdata_o = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      rdata_o = rdata_o | sel_data[i];
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer behind uart_rx: hunts SOF, checks LEN and XOR checksum, drains payload store-and-forward.
// Optional inter-byte timeout is compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = DEFAULT_SOF_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] out_len,
  output logic       busy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_ovr,
  output logic       err_timeout
);

  localparam int unsigned IW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  generate
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_bad_param
      $error("uart_frame_rx: MAX_LEN must be 1..255 and TIMEOUT_CLKS at least 1");
    end
  endgenerate

  frame_state_e    state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]      chk_q, chk_d;
  logic            err_len_q, err_len_d;
  logic            err_chk_q, err_chk_d;
  logic            err_ovr_q, err_ovr_d;
  logic            buf_we;
  logic [7:0]      buf_rdata;
  logic            timeout_hit;
  logic            byte_ok;
  logic            is_last;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_to_q, err_to_d;
  logic          timing;

  assign timing      = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign timeout_hit = timing && (to_cnt_q == TW'(TIMEOUT_CLKS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte that coincides with a timeout is discarded along with the frame.
  assign byte_ok = in_valid && !timeout_hit;
  assign is_last = (rd_idx_q == (len_q - IW'(1)));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    chk_d     = chk_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    buf_we    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (byte_ok && (in_data == SOF_BYTE)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (byte_ok) begin
          if ((in_data == 8'h00) || (in_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d    = in_data[IW-1:0];
            chk_d    = in_data;
            wr_idx_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (byte_ok) begin
          buf_we   = 1'b1;
          chk_d    = frame_chk(chk_q, in_data);
          wr_idx_d = wr_idx_q + IW'(1);
          if ((wr_idx_q + IW'(1)) == len_q) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (byte_ok) begin
          if (in_data == chk_q) begin
            rd_idx_d = '0;
            state_d  = DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = HUNT;
          end
        end
      end

      DRAIN: begin
        // No backpressure upstream: anything arriving now is lost.
        if (in_valid) begin
          err_ovr_d = 1'b1;
        end
        if (out_ready) begin
          rd_idx_d = rd_idx_q + IW'(1);
          if (is_last) begin
            state_d = HUNT;
          end
        end
      end

      default: state_d = HUNT;
    endcase

    if (timeout_hit) begin
      state_d = HUNT;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_comb begin
    err_to_d = timeout_hit;
    if (!timing || (state_d != state_q) || byte_ok) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      chk_q     <= 8'h00;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      chk_q     <= chk_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (in_data),
    .raddr_i (rd_idx_q),
    .rdata_o (buf_rdata)
  );

  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? buf_rdata : 8'h00;
  assign out_last  = out_valid && is_last;
  assign out_len   = 8'(len_q);
  assign busy      = (state_q != HUNT);
  assign err_len   = err_len_q;
  assign err_chk   = err_chk_q;
  assign err_ovr   = err_ovr_q;

endmodule
